uart_fifo: RTL and testbench

UART_FIFO -- requirements
Module: uart_fifo

---
 rtl/uart_fifo.sv | 346 ++++++++++++++++++++++++++++++++++
 tb/tb_uart_fifo.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo.sv
// UART with memory-mapped control, TX/RX byte FIFOs, programmable divisor,
// optional parity and a level interrupt. One clock domain; rx is synchronised.
module uart_fifo #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DEPTH_LOG2   = 4,
  parameter int PARITY       = 0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        tx,
  input  logic        rx,
  input  logic [5:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic        write_enable,
  input  logic        read_enable,
  output logic        irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [15:0]           DIV_RESET  = 16'(CLKS_PER_BIT);
  localparam logic [15:0]           DIV_MIN    = 16'd4;
  localparam logic [CW-1:0]         FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0]         CNT_ONE    = CW'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } uart_state_t;

  // ---------------- register decode ----------------
  logic sel_status, sel_div, sel_txdata, sel_rxdata, sel_irqen;
  logic wr_status, wr_div, wr_txdata, wr_irqen;

  assign sel_status = (addr == 6'h00);
  assign sel_div    = (addr == 6'h04);
  assign sel_txdata = (addr == 6'h08);
  assign sel_rxdata = (addr == 6'h0C);
  assign sel_irqen  = (addr == 6'h10);

  assign wr_status = write_enable & sel_status;
  assign wr_div    = write_enable & sel_div;
  assign wr_txdata = write_enable & sel_txdata;
  assign wr_irqen  = write_enable & sel_irqen;

  logic [15:0] div_reg;
  logic [2:0]  irq_en_reg;
  logic [3:0]  flag_reg;   // {tx_ovf, parity_err, frame_err, rx_ovf}
  logic [3:0]  flag_set;

  // ---------------- TX FIFO ----------------
  logic [7:0]            tx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg;
  logic [CW-1:0]         tx_count_reg;
  logic                  tx_full, tx_empty, tx_push, tx_pop;
  logic [7:0]            tx_head;

  assign tx_full  = (tx_count_reg == FULL_COUNT);
  assign tx_empty = (tx_count_reg == '0);
  assign tx_push  = wr_txdata & ~tx_full;
  assign tx_head  = tx_mem[tx_rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_reg] <= data_in[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
      tx_count_reg  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + PTR_ONE;
      if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + PTR_ONE;
      case ({tx_push, tx_pop})
        2'b10:   tx_count_reg <= tx_count_reg + CNT_ONE;
        2'b01:   tx_count_reg <= tx_count_reg - CNT_ONE;
        default: tx_count_reg <= tx_count_reg;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  uart_state_t tx_state_reg;
  logic [15:0] tx_cnt_reg, tx_div_reg;
  logic [7:0]  tx_shift_reg;
  logic [2:0]  tx_bit_reg;
  logic        tx_par_reg, tx_reg, tx_bit_end, tx_idle;

  assign tx_bit_end = (tx_cnt_reg == tx_div_reg - 16'd1);
  // A new frame starts from IDLE, or straight out of STOP so bursts leave no gap.
  assign tx_pop  = ~tx_empty & ((tx_state_reg == S_IDLE) |
                                ((tx_state_reg == S_STOP) & tx_bit_end));
  assign tx_idle = tx_empty & (tx_state_reg == S_IDLE);
  assign tx      = tx_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_reg <= S_IDLE;
      tx_cnt_reg   <= '0;
      tx_div_reg   <= DIV_RESET;
      tx_shift_reg <= '0;
      tx_bit_reg   <= '0;
      tx_par_reg   <= 1'b0;
      tx_reg       <= 1'b1;
    end else if (tx_pop) begin
      tx_state_reg <= S_START;
      tx_cnt_reg   <= '0;
      tx_div_reg   <= div_reg;
      tx_shift_reg <= tx_head;
      tx_bit_reg   <= '0;
      tx_par_reg   <= (PARITY == 2) ? ~(^tx_head) : ^tx_head;
      tx_reg       <= 1'b0;
    end else begin
      case (tx_state_reg)
        S_IDLE: tx_reg <= 1'b1;
        S_START: begin
          if (tx_bit_end) begin
            tx_cnt_reg   <= '0;
            tx_state_reg <= S_DATA;
            tx_reg       <= tx_shift_reg[0];
          end else begin
            tx_cnt_reg <= tx_cnt_reg + 16'd1;
          end
        end
        S_DATA: begin
          if (tx_bit_end) begin
            tx_cnt_reg <= '0;
            if (tx_bit_reg == 3'd7) begin
              tx_state_reg <= (PARITY != 0) ? S_PAR : S_STOP;
              tx_reg       <= (PARITY != 0) ? tx_par_reg : 1'b1;
            end else begin
              tx_bit_reg   <= tx_bit_reg + 3'd1;
              tx_shift_reg <= tx_shift_reg >> 1;
              tx_reg       <= tx_shift_reg[1];
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg + 16'd1;
          end
        end
        S_PAR: begin
          if (tx_bit_end) begin
            tx_cnt_reg   <= '0;
            tx_state_reg <= S_STOP;
            tx_reg       <= 1'b1;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + 16'd1;
          end
        end
        S_STOP: begin
          if (tx_bit_end) begin
            tx_cnt_reg   <= '0;
            tx_state_reg <= S_IDLE;
            tx_reg       <= 1'b1;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + 16'd1;
          end
        end
        default: begin
          tx_state_reg <= S_IDLE;
          tx_reg       <= 1'b1;
        end
      endcase
    end
  end

  // ---------------- RX synchroniser ----------------
  logic rx_sync1_reg, rx_sync2_reg, rx_prev_reg, rx_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync1_reg <= 1'b1;
      rx_sync2_reg <= 1'b1;
      rx_prev_reg  <= 1'b1;
    end else begin
      rx_sync1_reg <= rx;
      rx_sync2_reg <= rx_sync1_reg;
      rx_prev_reg  <= rx_sync2_reg;
    end
  end

  assign rx_fall = rx_prev_reg & ~rx_sync2_reg;

  // ---------------- RX FIFO ----------------
  logic [7:0]            rx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rx_wr_ptr_reg, rx_rd_ptr_reg;
  logic [CW-1:0]         rx_count_reg;
  logic                  rx_full, rx_empty, rx_push, rx_pop;
  logic [7:0]            rx_head;

  uart_state_t rx_state_reg;
  logic [15:0] rx_cnt_reg, rx_div_reg, rx_half;
  logic [7:0]  rx_shift_reg;
  logic [2:0]  rx_bit_reg;
  logic        rx_par_bad_reg, rx_bit_end, rx_par_exp;
  logic        rx_stop_sample, rx_frame_ok;

  assign rx_full  = (rx_count_reg == FULL_COUNT);
  assign rx_empty = (rx_count_reg == '0);
  assign rx_head  = rx_mem[rx_rd_ptr_reg];
  assign rx_pop   = read_enable & sel_rxdata & ~rx_empty;

  assign rx_half        = rx_div_reg >> 1;
  assign rx_bit_end     = (rx_cnt_reg == rx_div_reg - 16'd1);
  assign rx_par_exp     = (PARITY == 2) ? ~(^rx_shift_reg) : ^rx_shift_reg;
  assign rx_stop_sample = (rx_state_reg == S_STOP) & rx_bit_end;
  assign rx_frame_ok    = rx_stop_sample & rx_sync2_reg & ~rx_par_bad_reg;
  assign rx_push        = rx_frame_ok & ~rx_full;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr_reg] <= rx_shift_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr_ptr_reg <= '0;
      rx_rd_ptr_reg <= '0;
      rx_count_reg  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + PTR_ONE;
      if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + PTR_ONE;
      case ({rx_push, rx_pop})
        2'b10:   rx_count_reg <= rx_count_reg + CNT_ONE;
        2'b01:   rx_count_reg <= rx_count_reg - CNT_ONE;
        default: rx_count_reg <= rx_count_reg;
      endcase
    end
  end

  // ---------------- RX FSM ----------------
  // The start bit is checked half a bit in; later samples are spaced one full
  // bit from there, so every bit is taken near its centre.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_reg   <= S_IDLE;
      rx_cnt_reg     <= '0;
      rx_div_reg     <= DIV_RESET;
      rx_shift_reg   <= '0;
      rx_bit_reg     <= '0;
      rx_par_bad_reg <= 1'b0;
    end else begin
      case (rx_state_reg)
        S_IDLE: begin
          if (rx_fall) begin
            rx_state_reg   <= S_START;
            rx_cnt_reg     <= '0;
            rx_div_reg     <= div_reg;
            rx_bit_reg     <= '0;
            rx_par_bad_reg <= 1'b0;
          end
        end
        S_START: begin
          if (rx_cnt_reg == rx_half) begin
            rx_cnt_reg   <= '0;
            rx_state_reg <= rx_sync2_reg ? S_IDLE : S_DATA;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 16'd1;
          end
        end
        S_DATA: begin
          if (rx_bit_end) begin
            rx_cnt_reg   <= '0;
            rx_shift_reg <= {rx_sync2_reg, rx_shift_reg[7:1]};
            if (rx_bit_reg == 3'd7) begin
              rx_state_reg <= (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              rx_bit_reg <= rx_bit_reg + 3'd1;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 16'd1;
          end
        end
        S_PAR: begin
          if (rx_bit_end) begin
            rx_cnt_reg     <= '0;
            rx_par_bad_reg <= (rx_sync2_reg != rx_par_exp);
            rx_state_reg   <= S_STOP;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 16'd1;
          end
        end
        S_STOP: begin
          if (rx_bit_end) begin
            rx_cnt_reg   <= '0;
            rx_state_reg <= S_IDLE;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 16'd1;
          end
        end
        default: rx_state_reg <= S_IDLE;
      endcase
    end
  end

  // ---------------- control registers and sticky flags ----------------
  assign flag_set[0] = rx_frame_ok & rx_full;
  assign flag_set[1] = rx_stop_sample & ~rx_sync2_reg;
  assign flag_set[2] = (rx_state_reg == S_PAR) & rx_bit_end & (rx_sync2_reg != rx_par_exp);
  assign flag_set[3] = wr_txdata & tx_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_reg    <= DIV_RESET;
      irq_en_reg <= '0;
      flag_reg   <= '0;
    end else begin
      if (wr_div)   div_reg    <= (data_in[15:0] < DIV_MIN) ? DIV_MIN : data_in[15:0];
      if (wr_irqen) irq_en_reg <= data_in[2:0];
      // A new event in the same cycle as a clear wins, so no event is lost.
      flag_reg <= flag_set | (flag_reg & ~({4{wr_status}} & data_in[6:3]));
    end
  end

  // ---------------- read mux and interrupt ----------------
  logic [31:0] status;

  always_comb begin
    status          = '0;
    status[0]       = rx_empty;
    status[1]       = tx_full;
    status[2]       = tx_idle;
    status[6:3]     = flag_reg;
    status[8 +: CW] = rx_count_reg;
    status[16 +: CW] = tx_count_reg;
  end

  always_comb begin
    data_out = '0;
    case (addr)
      6'h00: data_out = status;
      6'h04: data_out[15:0] = div_reg;
      6'h0C: if (!rx_empty) data_out[7:0] = rx_head;
      6'h10: data_out[2:0] = irq_en_reg;
      default: data_out = '0;
    endcase
  end

  assign irq = (irq_en_reg[0] & ~rx_empty) |
               (irq_en_reg[1] & tx_idle) |
               (irq_en_reg[2] & (|flag_reg));

  logic unused_bits;
  assign unused_bits = ^data_in[31:16];

endmodule

// File: tb/tb_uart_fifo.sv
// Scoreboard bench for uart_fifo: unit 0 without parity, unit 1 with even parity.
// Stimulus queues expectations; monitor processes compare register reads and TX frames.
module tb_uart_fifo;

  localparam int BIT_CLKS = 16;
  localparam int K_DATA = 0;
  localparam int K_IRQ  = 1;
  localparam int K_TX   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        tx_v   [2];
  logic        rx_v   [2];
  logic        we_v   [2];
  logic        re_v   [2];
  logic        irq_v  [2];
  logic [5:0]  addr_v [2];
  logic [31:0] wdata_v[2];
  logic [31:0] rdata_v[2];

  uart_fifo #(.CLKS_PER_BIT(16), .DEPTH_LOG2(2), .PARITY(0)) dut (
    .clk(clk), .rst(rst), .tx(tx_v[0]), .rx(rx_v[0]), .addr(addr_v[0]),
    .data_in(wdata_v[0]), .data_out(rdata_v[0]), .write_enable(we_v[0]),
    .read_enable(re_v[0]), .irq(irq_v[0]));

  uart_fifo #(.CLKS_PER_BIT(16), .DEPTH_LOG2(2), .PARITY(1)) dut_p (
    .clk(clk), .rst(rst), .tx(tx_v[1]), .rx(rx_v[1]), .addr(addr_v[1]),
    .data_in(wdata_v[1]), .data_out(rdata_v[1]), .write_enable(we_v[1]),
    .read_enable(re_v[1]), .irq(irq_v[1]));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    string       name;
    int          unit;
    int          kind;
    logic [31:0] exp;
  } chk_t;

  typedef struct {
    logic [7:0] b;
    bit         b2b;
  } txe_t;

  chk_t chk_q[$];
  txe_t tx_exp[$];
  logic chk_req = 1'b0;

  // ---------------- register/irq/tx-level monitor ----------------
  initial begin : chk_mon
    chk_t        c;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      #2;
      if (chk_req && chk_q.size() > 0) begin
        c = chk_q.pop_front();
        case (c.kind)
          K_IRQ:   act = {31'b0, irq_v[c.unit]};
          K_TX:    act = {31'b0, tx_v[c.unit]};
          default: act = rdata_v[c.unit];
        endcase
        total = total + 1;
        if (act !== c.exp) begin
          bad = bad + 1;
          $display("FAIL %s (u%0d): got %h expected %h", c.name, c.unit, act, c.exp);
        end else begin
          $display("ok   %s (u%0d): %h", c.name, c.unit, act);
        end
      end
    end
  end

  // ---------------- TX frame monitor (unit 0) ----------------
  initial begin : tx_mon
    int         start_cyc, last_start, gap;
    logic [9:0] early, late;
    bit         aborted, shape_ok;
    txe_t       e;
    last_start = -100000;
    forever begin
      @(negedge clk);
      if (!rst && tx_v[0] === 1'b0) begin
        start_cyc = cyc;
        aborted   = 1'b0;
        early     = '0;
        late      = '0;
        for (int off = 1; off < 10 * BIT_CLKS; off++) begin
          @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          if (off % BIT_CLKS == 1)  early[off / BIT_CLKS] = tx_v[0];
          if (off % BIT_CLKS == 14) late[off / BIT_CLKS]  = tx_v[0];
        end
        if (aborted) begin
          $display("tx frame cut by reset at cycle %0d", cyc);
        end else if (tx_exp.size() == 0) begin
          total = total + 1;
          bad   = bad + 1;
          $display("FAIL tx_unexpected: got frame bits %b expected no frame", early);
        end else begin
          e = tx_exp.pop_front();
          shape_ok = (early == late) && (early[0] == 1'b0) && (early[9] == 1'b1);
          total = total + 1;
          if (!shape_ok || early[8:1] != e.b) begin
            bad = bad + 1;
            $display("FAIL tx_frame: got bits early=%b late=%b expected byte %h", early, late, e.b);
          end else begin
            $display("ok   tx_frame: byte %h at cycle %0d", e.b, start_cyc);
          end
          if (e.b2b) begin
            gap   = start_cyc - last_start;
            total = total + 1;
            if (gap != 10 * BIT_CLKS) begin
              bad = bad + 1;
              $display("FAIL tx_gap: got %0d clocks expected %0d", gap, 10 * BIT_CLKS);
            end else begin
              $display("ok   tx_gap: %0d clocks", gap);
            end
          end
          last_start = start_cyc;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic bus_wr(input int u, input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    addr_v[u]  = a;
    wdata_v[u] = d;
    we_v[u]    = 1'b1;
    @(negedge clk);
    we_v[u] = 1'b0;
    $display("wr   u%0d [%h] <= %h", u, a, d);
  endtask

  task automatic check(input int u, input int kind, input logic [5:0] a,
                       input bit pop, input logic [31:0] exp, input string name);
    chk_t c;
    @(negedge clk);
    addr_v[u] = a;
    re_v[u]   = pop;
    c.name = name;
    c.unit = u;
    c.kind = kind;
    c.exp  = exp;
    chk_q.push_back(c);
    chk_req = 1'b1;
    @(negedge clk);
    chk_req = 1'b0;
    re_v[u] = 1'b0;
  endtask

  task automatic send_bit(input int u, input logic b);
    @(negedge clk);
    rx_v[u] = b;
    repeat (BIT_CLKS - 1) @(negedge clk);
  endtask

  task automatic send_rx(input int u, input logic [7:0] d, input bit has_par,
                         input logic par, input logic stop);
    send_bit(u, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(u, d[i]);
    if (has_par) send_bit(u, par);
    send_bit(u, stop);
    rx_v[u] = 1'b1;
    $display("rx   u%0d frame %h par=%0d/%b stop=%b", u, d, has_par, par, stop);
  endtask

  task automatic expect_tx(input logic [7:0] b, input bit b2b);
    txe_t e;
    e.b   = b;
    e.b2b = b2b;
    tx_exp.push_back(e);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    for (int u = 0; u < 2; u++) begin
      rx_v[u] = 1'b1; we_v[u] = 1'b0; re_v[u] = 1'b0;
      addr_v[u] = '0; wdata_v[u] = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    check(0, K_DATA, 6'h00, 0, 32'h0000_0005, "rst_status");
    check(0, K_DATA, 6'h04, 0, 32'd16,        "rst_div");
    check(0, K_DATA, 6'h10, 0, 32'h0,         "rst_irqen");
    check(0, K_IRQ,  6'h00, 0, 32'h0,         "rst_irq");
    check(1, K_DATA, 6'h00, 0, 32'h0000_0005, "rst_status_p");
    check(0, K_DATA, 6'h14, 0, 32'h0,         "unmapped");

    // divisor clamp and upper-bit masking
    bus_wr(0, 6'h04, 32'd2);
    check(0, K_DATA, 6'h04, 0, 32'd4,  "div_clamp");
    bus_wr(0, 6'h04, 32'h0001_0010);
    check(0, K_DATA, 6'h04, 0, 32'd16, "div_rw");

    // single byte; divisor rewritten mid-frame must not disturb it
    expect_tx(8'hA5, 1'b0);
    bus_wr(0, 6'h08, 32'hA5);
    repeat (40) @(negedge clk);
    bus_wr(0, 6'h04, 32'd20);
    check(0, K_DATA, 6'h04, 0, 32'd20, "div_mid");
    repeat (140) @(negedge clk);
    bus_wr(0, 6'h04, 32'd16);
    check(0, K_DATA, 6'h00, 0, 32'h0000_0005, "a5_idle");

    // TX overflow with the line busy
    expect_tx(8'h99, 1'b0);
    bus_wr(0, 6'h08, 32'h99);
    repeat (5) @(negedge clk);
    expect_tx(8'h11, 1'b1);
    expect_tx(8'h22, 1'b1);
    expect_tx(8'h33, 1'b1);
    expect_tx(8'h44, 1'b1);
    bus_wr(0, 6'h08, 32'h11);
    bus_wr(0, 6'h08, 32'h22);
    bus_wr(0, 6'h08, 32'h33);
    bus_wr(0, 6'h08, 32'h44);
    bus_wr(0, 6'h08, 32'h55);
    check(0, K_DATA, 6'h00, 0, 32'h0004_0043, "txovf_status");
    bus_wr(0, 6'h00, 32'h40);
    check(0, K_DATA, 6'h00, 0, 32'h0004_0003, "txovf_w1c");
    repeat (820) @(negedge clk);
    check(0, K_DATA, 6'h00, 0, 32'h0000_0005, "burst_idle");
    bus_wr(0, 6'h10, 32'd2);
    check(0, K_IRQ, 6'h00, 0, 32'h1, "irq_txidle");
    bus_wr(0, 6'h10, 32'd1);
    check(0, K_IRQ, 6'h00, 0, 32'h0, "irq_rx_none");

    // single RX byte, then pop, then pop of an empty FIFO
    send_rx(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check(0, K_DATA, 6'h00, 0, 32'h0000_0104, "rx1_status");
    check(0, K_IRQ,  6'h00, 0, 32'h1,         "irq_rx");
    check(0, K_DATA, 6'h0C, 1, 32'h0000_003C, "rx1_data");
    check(0, K_DATA, 6'h00, 0, 32'h0000_0005, "rx1_empty");
    check(0, K_IRQ,  6'h00, 0, 32'h0,         "irq_rx_clr");
    check(0, K_DATA, 6'h0C, 1, 32'h0,         "rx_pop_empty");
    check(0, K_DATA, 6'h00, 0, 32'h0000_0005, "rx_pop_empty_status");
    bus_wr(0, 6'h10, 32'd0);

    // RX overflow: five frames, four kept
    for (int i = 1; i <= 5; i++) send_rx(0, 8'(i), 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check(0, K_DATA, 6'h00, 0, 32'h0000_040C, "rxovf_status");
    for (int i = 1; i <= 4; i++) check(0, K_DATA, 6'h0C, 1, 32'(i), "rxovf_data");
    check(0, K_DATA, 6'h00, 0, 32'h0000_000D, "rxovf_after");
    bus_wr(0, 6'h00, 32'h08);
    check(0, K_DATA, 6'h00, 0, 32'h0000_0005, "rxovf_w1c");

    // even-parity unit: good frame, bad parity, low stop bit
    send_rx(1, 8'h81, 1'b1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check(1, K_DATA, 6'h00, 0, 32'h0000_0104, "par_good_status");
    check(1, K_DATA, 6'h0C, 1, 32'h0000_0081, "par_good_data");
    send_rx(1, 8'h3C, 1'b1, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check(1, K_DATA, 6'h00, 0, 32'h0000_0025, "par_bad_status");
    check(1, K_IRQ,  6'h00, 0, 32'h0,         "par_irq_off");
    send_rx(1, 8'h55, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check(1, K_DATA, 6'h00, 0, 32'h0000_0035, "frame_err_status");
    bus_wr(1, 6'h10, 32'd4);
    check(1, K_IRQ,  6'h00, 0, 32'h1,         "par_irq_on");
    bus_wr(1, 6'h00, 32'h30);
    check(1, K_IRQ,  6'h00, 0, 32'h0,         "irq_w1c");
    check(1, K_DATA, 6'h00, 0, 32'h0000_0005, "par_w1c_status");

    // reset in the middle of a TX frame
    bus_wr(0, 6'h10, 32'd7);
    bus_wr(0, 6'h04, 32'd32);
    bus_wr(0, 6'h08, 32'h77);
    repeat (6) @(negedge clk);
    check(0, K_TX, 6'h00, 0, 32'h0, "tx_busy");
    begin
      chk_t c;
      @(negedge clk);
      rst = 1'b1;
      c.name = "tx_rst_same_cycle";
      c.unit = 0;
      c.kind = K_TX;
      c.exp  = 32'h1;
      chk_q.push_back(c);
      chk_req = 1'b1;
      @(negedge clk);
      chk_req = 1'b0;
    end
    check(0, K_IRQ,  6'h00, 0, 32'h0,         "irq_in_rst");
    check(0, K_DATA, 6'h00, 0, 32'h0000_0005, "status_in_rst");
    @(negedge clk);
    rst = 1'b0;
    check(0, K_DATA, 6'h00, 0, 32'h0000_0005, "rst_mid_status");
    check(0, K_DATA, 6'h04, 0, 32'd16,        "rst_mid_div");
    check(0, K_DATA, 6'h10, 0, 32'h0,         "rst_mid_irqen");
    check(0, K_IRQ,  6'h00, 0, 32'h0,         "rst_mid_irq");
    repeat (400) @(negedge clk);
    check(0, K_DATA, 6'h00, 0, 32'h0000_0005, "rst_mid_quiet");

    total = total + 1;
    if (tx_exp.size() != 0) begin
      bad = bad + 1;
      $display("FAIL tx_pending: got %0d unsent frames expected 0", tx_exp.size());
    end else begin
      $display("ok   tx_pending: 0");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
